// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg
// Shared definitions for the FIFO burst-drain block: the drain FSM state
// type and the default geometry used when the top is instantiated without
// parameter overrides.
package fifo_drain_pkg;

  // Default geometry: 16-bit words, 16-deep upstream FIFO, 4-word bursts.
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_BURST_LEN  = 4;

  // IDLE  : waiting for enough words for a burst or for a flush request
  // BURST : popping a fixed-length burst
  // FLUSH : popping everything left in the FIFO
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

endpackage : fifo_drain_pkg

// File: rtl/drain_out_reg.sv
// drain_out_reg
// Single-entry output register for the burst drain. A load captures the
// FIFO head word (and its end-of-burst marker) and raises m_valid one cycle
// after the pop. The word is held unchanged until the downstream side
// accepts it.
//
// Optional feature: define FIFO_DRAIN_PARITY_EN to add m_parity, the XOR
// of the loaded word, registered alongside m_data.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   load       in   capture load_data/load_last this cycle
//   load_data  in   word to capture (FIFO head)
//   load_last  in   word closes a burst or flush
//   m_ready    in   downstream accept
//   m_valid    out  output word valid
//   m_data     out  output word
//   m_last     out  output word is the last of its burst/flush
//   m_parity   out  (FIFO_DRAIN_PARITY_EN only) XOR of m_data
module drain_out_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
`ifdef FIFO_DRAIN_PARITY_EN
  output logic                  m_last,
  output logic                  m_parity
`else
  output logic                  m_last
`endif
);

  // A load takes priority over a completing handshake: when the current
  // word is accepted in the same cycle a new one is popped, the register
  // simply refills and m_valid stays high. m_data is only written on a
  // load, so it stays stable through any stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_last  <= load_last;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

`ifdef FIFO_DRAIN_PARITY_EN
  // Parity travels with the word, so it only changes on a load.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_parity <= 1'b0;
    end else if (load) begin
      m_parity <= ^load_data;
    end
  end
`endif

endmodule : drain_out_reg

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain
// Drains an upstream first-word-fall-through FIFO onto a valid/ready
// stream. Once the FIFO holds at least BURST_LEN words a fixed-length
// burst is popped; a flush request drains whatever remains. The final word
// of each burst or flush is tagged with m_last, and burst_cnt counts
// accepted m_last words.
//
// Optional feature: define FIFO_DRAIN_PARITY_EN to add the m_parity output.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   fifo_data   in   FIFO head word, valid when fifo_empty=0
//   fifo_empty  in   FIFO empty flag
//   fifo_depth  in   FIFO occupancy (ADDR_WIDTH+1 bits)
//   fifo_ren    out  combinational pop request
//   flush       in   single-cycle request to drain everything left
//   m_valid     out  downstream word valid
//   m_ready     in   downstream accept
//   m_data      out  downstream word
//   m_last      out  last word of a burst or flush
//   busy        out  FSM active or output word still pending
//   burst_cnt   out  count of accepted m_last words, wraps at 255
//   m_parity    out  (FIFO_DRAIN_PARITY_EN only) XOR of m_data
module fifo_burst_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_depth,
  output logic                  fifo_ren,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
`ifdef FIFO_DRAIN_PARITY_EN
  output logic [7:0]            burst_cnt,
  output logic                  m_parity
`else
  output logic [7:0]            burst_cnt
`endif
);

  localparam logic [ADDR_WIDTH:0] BURST_LEN_W = (ADDR_WIDTH+1)'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0] ONE_W       = (ADDR_WIDTH+1)'(1);

  drain_state_t          state;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  flush_pending;
  logic                  flush_req;
  logic                  draining;
  logic                  load;
  logic                  last_word;

  // A flush arriving this cycle is treated the same as one already latched,
  // so an IDLE block reacts to the pulse without an extra cycle.
  assign flush_req = flush_pending | flush;

  assign draining = (state == BURST) || (state == FLUSH);

  // Pop only when there is a word, the output register is free (or being
  // emptied this cycle), and a burst or flush is in progress. fifo_empty
  // gates the pop directly so an empty FIFO is never read.
  assign load     = ~fifo_empty & (~m_valid | m_ready) & draining;
  assign fifo_ren = load;

  // The word being popped closes the transfer when it is the final word
  // of a burst, or the only word left during a flush.
  assign last_word = ((state == BURST) && (remaining == ONE_W)) ||
                     ((state == FLUSH) && (fifo_depth == ONE_W));

  assign busy = (state != IDLE) | m_valid;

  // Drain FSM. A flush raised while a burst is running is only latched;
  // the burst completes first, then IDLE sees the pending request and
  // moves into FLUSH if anything is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      remaining     <= '0;
      flush_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            flush_pending <= 1'b0;
            if (!fifo_empty) begin
              state <= FLUSH;
            end
          end else if (fifo_depth >= BURST_LEN_W) begin
            state     <= BURST;
            remaining <= BURST_LEN_W;
          end
        end

        BURST: begin
          flush_pending <= flush_req;
          if (load) begin
            remaining <= remaining - ONE_W;
            if (remaining == ONE_W) begin
              state <= IDLE;
            end
          end
        end

        FLUSH: begin
          flush_pending <= flush_req;
          if (load && (fifo_depth == ONE_W)) begin
            state <= IDLE;
          end else if (fifo_empty) begin
            state <= IDLE;
          end
        end

        default: begin
          state         <= IDLE;
          remaining     <= '0;
          flush_pending <= 1'b0;
        end
      endcase
    end
  end

  // Counts completed transfers as seen by the consumer, i.e. when the
  // m_last word is actually accepted rather than when it is popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (m_valid && m_ready && m_last) begin
      burst_cnt <= burst_cnt + 8'd1;
    end
  end

  drain_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (fifo_data),
    .load_last (last_word),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
`ifdef FIFO_DRAIN_PARITY_EN
    .m_last    (m_last),
    .m_parity  (m_parity)
`else
    .m_last    (m_last)
`endif
  );

endmodule : fifo_burst_drain
